// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter and its round-robin picker.
package mem_bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int MEM_WSTRB_WIDTH      = 4;
    localparam int LOCK_WATCHDOG_CYCLES = 16;
    localparam int GRANT_ID_W           = 3;

endpackage

// File: rtl/mem_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first eligible requester after `last`,
// searching upward with wrap-around. Also used by the IRQ scheduler.
module rr_priority_picker
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]            req,
    input  logic [GRANT_ID_W-1:0]   last,
    input  logic [N-1:0]            mask,
    output logic [N-1:0]            grant,
    output logic [GRANT_ID_W-1:0]   idx,
    output logic                    any
);

    logic [N-1:0] elig;
    int           best;

    // Distance from last+1 to i, modulo N; smaller distance wins.
    function automatic int rr_dist(input int i, input logic [GRANT_ID_W-1:0] l);
        return (i - int'(l) - 1 + 16 * N) % N;
    endfunction

    assign elig = req & mask;

    always_comb begin
        grant = '0;
        idx   = '0;
        best  = N;
        for (int i = 0; i < N; i++) begin
            if (elig[i] && (rr_dist(i, last) < best)) begin
                best = rr_dist(i, last);
                idx  = GRANT_ID_W'(i);
            end
        end
        any = |elig;
        if (any) grant = N'(1) << idx;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ masters,
// with atomic-sequence lock hold and a no-response timeout fault.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_REQ*32-1:0]                req_wdata,
    input  logic [NUM_REQ*MEM_WSTRB_WIDTH-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   req_fault,
    output logic [31:0]                          req_rdata,
    output logic                                 mem_valid,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [31:0]                          mem_wdata,
    output logic [MEM_WSTRB_WIDTH-1:0]           mem_wstrb,
    input  logic                                 mem_ready,
    input  logic [31:0]                          mem_rdata,
    output logic [GRANT_ID_W-1:0]                grant_id
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int WD_W  = $clog2(LOCK_WATCHDOG_CYCLES + 1);

    arb_state_e              state, state_nxt;
    logic [GRANT_ID_W-1:0]   last, lock_id, pick_idx;
    logic                    lock_held, pick_any;
    logic [WD_W-1:0]         wd_cnt;
    logic [CNT_W-1:0]        to_cnt;
    logic [NUM_REQ-1:0]      mask, pick_grant, gnt_oh;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [31:0]             sel_wdata;
    logic [MEM_WSTRB_WIDTH-1:0] sel_wstrb;
    logic                    done, timeout_hit, lock_bit;

    // While a lock is held only the owner is eligible.
    assign mask = lock_held ? (NUM_REQ'(1) << lock_id) : '1;

    rr_priority_picker #(.N(NUM_REQ)) u_picker (
        .req   (req_valid),
        .last  (last),
        .mask  (mask),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*32 +: 32];
                sel_wstrb = req_wstrb[i*MEM_WSTRB_WIDTH +: MEM_WSTRB_WIDTH];
            end
        end
    end

    assign gnt_oh      = NUM_REQ'(1) << grant_id;
    assign lock_bit    = |(req_lock & gnt_oh);
    assign done        = (state == ARB_BUSY) && mem_ready;
    // mem_ready takes priority over an expiring timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ARB_BUSY) && !mem_ready &&
                         (to_cnt == CNT_W'(TIMEOUT_CYCLES));

    assign req_ready = (done || timeout_hit) ? gnt_oh : '0;
    assign req_fault = timeout_hit ? gnt_oh : '0;
    assign req_rdata = done ? mem_rdata : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (pick_any) state_nxt = ARB_BUSY;
            ARB_BUSY: if (done || timeout_hit) state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ARB_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            grant_id  <= '0;
            last      <= GRANT_ID_W'(NUM_REQ - 1);
            lock_held <= 1'b0;
            lock_id   <= '0;
            wd_cnt    <= '0;
            to_cnt    <= '0;
        end else if (state == ARB_IDLE) begin
            if (pick_any) begin
                grant_id  <= pick_idx;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_wstrb <= sel_wstrb;
                mem_valid <= 1'b1;
                to_cnt    <= '0;
                wd_cnt    <= '0;
            end else if (lock_held) begin
                // Owner went quiet: release after the watchdog window.
                if (wd_cnt == WD_W'(LOCK_WATCHDOG_CYCLES - 1)) begin
                    lock_held <= 1'b0;
                    wd_cnt    <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end else begin
            if (done) begin
                mem_valid <= 1'b0;
                last      <= grant_id;
                to_cnt    <= '0;
                lock_held <= lock_bit;
                lock_id   <= grant_id;
            end else if (timeout_hit) begin
                mem_valid <= 1'b0;
                last      <= grant_id;
                to_cnt    <= '0;
                lock_held <= 1'b0;
            end else if (to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized + directed bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int N  = 3;
    localparam int T  = 8;
    localparam int AW = 32;
    localparam int WD = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      req_valid, req_lock;
    logic [N*AW-1:0]   req_addr;
    logic [N*32-1:0]   req_wdata;
    logic [N*4-1:0]    req_wstrb;
    logic [N-1:0]      req_ready, req_fault;
    logic [31:0]       req_rdata;
    logic              mem_valid;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [2:0]        grant_id;

    mem_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ready(req_ready), .req_fault(req_fault), .req_rdata(req_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: transaction-level view of the arbiter.
    bit        m_busy, m_lock;
    int        m_gid, m_last, m_lock_id, m_idle_quiet, m_busy_cycles;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [N-1:0] last_rdy;
    int        grant_log[$];

    logic [N-1:0] obs_ready, obs_fault;
    logic [31:0]  obs_rdata;
    logic         obs_valid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_lock = 0; m_gid = 0; m_last = N - 1; m_lock_id = 0;
        m_idle_quiet = 0; m_busy_cycles = 0; last_rdy = '0;
        grant_list_clear();
    endtask

    task automatic grant_list_clear();
        grant_log.delete();
    endtask

    // One clock cycle: check outputs at negedge, advance model, return at posedge+1.
    task automatic step();
        logic [N-1:0] e_rdy, e_flt;
        logic [31:0]  e_rdata;
        int           w;
        @(negedge clk);
        e_rdy = '0; e_flt = '0; e_rdata = '0;
        if (m_busy) begin
            if (mem_ready) begin
                e_rdy[m_gid] = 1'b1; e_rdata = mem_rdata;
            end else if (m_busy_cycles == T + 1) begin
                e_rdy[m_gid] = 1'b1; e_flt[m_gid] = 1'b1;
            end
        end
        obs_ready = req_ready; obs_fault = req_fault; obs_rdata = req_rdata; obs_valid = mem_valid;
        chk("mem_valid", mem_valid, m_busy);
        chk("grant_id", grant_id, m_gid);
        if (m_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wstrb", mem_wstrb, m_wstrb);
        end
        chk("req_ready", req_ready, e_rdy);
        chk("req_fault", req_fault, e_flt);
        if (|e_rdy) chk("req_rdata", req_rdata, e_rdata);

        if (m_busy) begin
            if (|e_rdy) begin
                m_busy = 0; m_last = m_gid;
                if (|e_flt) m_lock = 0;
                else begin m_lock = req_lock[m_gid]; m_lock_id = m_gid; end
                m_idle_quiet = 0;
            end else begin
                m_busy_cycles++;
            end
        end else begin
            w = -1;
            if (m_lock) begin
                if (req_valid[m_lock_id]) w = m_lock_id;
                else begin
                    m_idle_quiet++;
                    if (m_idle_quiet == WD) begin m_lock = 0; m_idle_quiet = 0; end
                end
            end else begin
                for (int k = 1; k <= N; k++)
                    if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
            end
            if (w >= 0) begin
                m_busy = 1; m_gid = w; m_busy_cycles = 1; m_idle_quiet = 0;
                m_addr = req_addr[w*32 +: 32]; m_wdata = req_wdata[w*32 +: 32];
                m_wstrb = req_wstrb[w*4 +: 4];
                grant_log.push_back(w);
            end
        end
        last_rdy = e_rdy;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_grant_id", grant_id, 3'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", mem_wstrb, 4'd0);
        chk("rst_req_ready", req_ready, 3'd0);
        model_reset();
        resetn = 1'b1;
    endtask

    task automatic new_fields(input int i);
        req_addr[i*32 +: 32]  = $urandom;
        req_wdata[i*32 +: 32] = $urandom;
        req_wstrb[i*4 +: 4]   = 4'($urandom_range(0, 15));
        req_lock[i]           = ($urandom_range(0, 3) == 0);
    endtask

    int hold[N];
    int delay, n, k;
    bit found;
    logic [N-1:0] f_rdy;
    logic [31:0]  f_rdata;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        resetn = 1'b0; req_valid = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; mem_ready = 1'b0; mem_rdata = '0;
        @(posedge clk); #1;

        // Single read from requester 0, ready on the 3rd BUSY cycle.
        do_reset();
        req_valid = 3'b001; req_addr[31:0] = 32'h1000_0000;
        step();
        step(); step();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("t1_ready", obs_ready, 3'b001);
        chk("t1_rdata", obs_rdata, 32'hDEAD_BEEF);
        mem_ready = 1'b0; req_valid = '0;
        step();
        chk("t1_valid_low", obs_valid, 1'b0);

        // Two continuous requesters alternate.
        req_valid = '0; do_reset();
        req_addr[31:0] = 32'hA000_0000; req_addr[63:32] = 32'hB000_0000;
        req_valid = 3'b011;
        for (int c = 0; c < 16; c++) begin
            mem_ready = m_busy && (m_busy_cycles == 2);
            step();
        end
        mem_ready = 1'b0;
        for (int g = 0; g < 4; g++)
            chk("t2_alternate", (grant_log.size() > g) ? grant_log[g] : -1, g % 2);

        // Lock hold: LR then SC by req 0 before req 1.
        req_valid = '0; do_reset();
        req_valid = 3'b011; req_lock = 3'b001;
        for (n = 0; n < 40 && grant_log.size() < 3; n++) begin
            mem_ready = m_busy;
            step();
            if (last_rdy[0]) req_lock[0] = 1'b0;
        end
        chk("t3_g0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        chk("t3_g1", (grant_log.size() > 1) ? grant_log[1] : -1, 0);
        chk("t3_g2", (grant_log.size() > 2) ? grant_log[2] : -1, 1);

        // Lock watchdog: owner goes quiet, req 1 gets in after 16 idle cycles.
        req_valid = '0; do_reset();
        req_valid = 3'b011; req_lock = 3'b001;
        found = 0;
        for (n = 0; n < 20 && !found; n++) begin
            mem_ready = m_busy;
            step();
            found = last_rdy[0];
        end
        chk("t4_lock_done", found, 1'b1);
        req_valid[0] = 1'b0; req_lock = '0; mem_ready = 1'b0;
        for (n = 0; n < 40 && grant_log.size() < 2; ) begin
            step(); n++;
        end
        chk("t4_release_cycles", n, 17);
        chk("t4_grant", (grant_log.size() > 1) ? grant_log[1] : -1, 1);

        // Timeout with no mem_ready, then a normal transfer.
        req_valid = '0; do_reset();
        req_valid = 3'b001; mem_ready = 1'b0;
        step();
        k = 0; found = 0;
        for (n = 1; n <= 12 && !found; n++) begin
            step();
            if (obs_fault != '0) begin
                k = n; found = 1; f_rdy = obs_ready; f_rdata = obs_rdata;
            end
        end
        chk("t5_fault_cycle", k, 9);
        chk("t5_fault_ready", f_rdy, 3'b001);
        chk("t5_fault_rdata", f_rdata, 32'd0);
        step();
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        chk("t5_after_ready", obs_ready, 3'b001);
        chk("t5_after_fault", obs_fault, 3'b000);
        mem_ready = 1'b0;

        // mem_ready coincident with counter==TIMEOUT: ready wins.
        req_valid = '0; do_reset();
        req_valid = 3'b010;
        step();
        repeat (8) step();
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        chk("t6_ready", obs_ready, 3'b010);
        chk("t6_fault", obs_fault, 3'b000);
        chk("t6_rdata", obs_rdata, 32'h1234_5678);
        mem_ready = 1'b0;

        // Asynchronous reset mid-BUSY.
        req_valid = '0; do_reset();
        req_valid = 3'b100;
        step(); step();
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #2 resetn = 1'b0;
        #1;
        chk("t7_async_valid", mem_valid, 1'b0);
        chk("t7_async_ready", req_ready, 3'b000);
        chk("t7_async_fault", req_fault, 3'b000);
        req_valid = 3'b111; mem_ready = 1'b0;
        do_reset();
        step();
        chk("t7_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        // Randomized traffic.
        req_valid = '0; req_lock = '0; do_reset();
        for (int i = 0; i < N; i++) hold[i] = 0;
        delay = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_busy) begin
                if (m_busy_cycles == 1) begin
                    k = $urandom_range(0, 9);
                    delay = (k < 7) ? 1 + (k % 4) : (k == 7) ? T + 1 : 99;
                end
                mem_ready = (m_busy_cycles == delay);
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
            end
            mem_rdata = $urandom;
            step();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if (last_rdy[i]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            hold[i] = req_lock[i] ? $urandom_range(0, 24) : $urandom_range(0, 3);
                            req_valid[i] = 1'b0;
                        end else begin
                            new_fields(i);
                        end
                    end
                end else if (hold[i] > 0) begin
                    hold[i]--;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    new_fields(i);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
